// File: rtl/dm_responder_pkg.sv
// Shared access-width codes and MMIO window constants for the data-memory responder.
package dm_responder_pkg;

    typedef enum logic [2:0] {
        DM_WORD              = 3'b000,
        DM_HALFWORD          = 3'b001,
        DM_HALFWORD_UNSIGNED = 3'b010,
        DM_BYTE              = 3'b011,
        DM_BYTE_UNSIGNED     = 3'b100
    } dm_type_e;

    localparam logic [23:0] MMIO_BASE    = 24'hFFFFFF;
    // MMIO register word offsets within the window (Addr_in[7:2])
    localparam logic [5:0]  MMIO_LED     = 6'd0;
    localparam logic [5:0]  MMIO_CYCLE   = 6'd1;
    localparam logic [5:0]  MMIO_ERRSTAT = 6'd2;
    localparam logic [5:0]  MMIO_ERRADDR = 6'd3;

endpackage

// File: rtl/dm_lane.sv
// Byte-lane formatter: store byte-enables/data, load extraction with sign control,
// and misalignment detection for one 32-bit word access.
module dm_lane
    import dm_responder_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  dm_type,
    input  logic [31:0] store_data,
    input  logic [31:0] raw_word,
    output logic [3:0]  byte_en,
    output logic [31:0] write_data,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        byte_en    = 4'b0000;
        write_data = store_data;
        load_data  = raw_word;
        misaligned = 1'b0;
        sel_byte   = raw_word[{addr_lo, 3'b000} +: 8];
        sel_half   = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
        case (dm_type)
            DM_HALFWORD, DM_HALFWORD_UNSIGNED: begin
                misaligned = addr_lo[0];
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                write_data = {2{store_data[15:0]}};
                load_data  = (dm_type == DM_HALFWORD) ? {{16{sel_half[15]}}, sel_half}
                                                      : {16'h0000, sel_half};
            end
            DM_BYTE, DM_BYTE_UNSIGNED: begin
                byte_en    = 4'b0001 << addr_lo;
                write_data = {4{store_data[7:0]}};
                load_data  = (dm_type == DM_BYTE) ? {{24{sel_byte[7]}}, sel_byte}
                                                  : {24'h000000, sel_byte};
            end
            default: begin
                // undefined codes behave as full-word accesses
                misaligned = (addr_lo != 2'b00);
                byte_en    = 4'b1111;
            end
        endcase
        if (misaligned) begin
            byte_en   = 4'b0000;
            load_data = 32'h0000_0000;
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Memory-side responder for the single-cycle core: byte-lane RAM, LED/cycle/error
// MMIO window and sticky access-error log. Loads are combinational.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [2:0]  dmType,
    output logic [31:0] Data_out,
    output logic [15:0] led_out,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] ram [DEPTH_WORDS];
    logic [31:0] led_reg, led_next;
    logic [31:0] cycle_reg;
    logic        err_reg;
    logic [31:0] err_addr_reg;

    logic          in_ram, in_mmio, out_of_range;
    logic [AW-1:0] ram_idx;
    logic [5:0]    mmio_off;
    logic [31:0]   mmio_rd, raw_word;
    logic [3:0]    byte_en;
    logic [31:0]   write_data, load_data;
    logic          misaligned;
    logic          led_we, errstat_clr, access_err;

    assign in_ram       = (Addr_in[31:16] == 16'h0000) &&
                          ({18'h0, Addr_in[15:2]} < 32'(DEPTH_WORDS));
    assign in_mmio      = (Addr_in[31:8] == MMIO_BASE);
    assign out_of_range = !in_ram && !in_mmio;
    assign ram_idx      = Addr_in[AW+1:2];
    assign mmio_off     = Addr_in[7:2];

    always_comb begin
        mmio_rd = 32'h0000_0000;
        case (mmio_off)
            MMIO_LED:     mmio_rd = led_reg;
            MMIO_CYCLE:   mmio_rd = cycle_reg;
            MMIO_ERRSTAT: mmio_rd = {31'h0, err_reg};
            MMIO_ERRADDR: mmio_rd = err_addr_reg;
            default:      mmio_rd = 32'h0000_0000;
        endcase
    end

    assign raw_word = in_ram  ? ram[ram_idx] :
                      in_mmio ? mmio_rd      : 32'h0000_0000;

    dm_lane u_lane (
        .addr_lo    (Addr_in[1:0]),
        .dm_type    (dmType),
        .store_data (Data_in),
        .raw_word   (raw_word),
        .byte_en    (byte_en),
        .write_data (write_data),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    assign Data_out = load_data;

    // RAM is not reset, but a store coinciding with reset is discarded
    always_ff @(posedge clk) begin
        if (reset && mem_w && in_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) ram[ram_idx][8*i +: 8] <= write_data[8*i +: 8];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_led_lane
            assign led_next[8*gi +: 8] = byte_en[gi] ? write_data[8*gi +: 8]
                                                     : led_reg[8*gi +: 8];
        end
    endgenerate

    assign led_we      = mem_w && in_mmio && (mmio_off == MMIO_LED);
    assign errstat_clr = mem_w && in_mmio && (mmio_off == MMIO_ERRSTAT) && !misaligned;
    assign access_err  = misaligned || out_of_range;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_reg      <= 32'h0000_0000;
            cycle_reg    <= 32'h0000_0000;
            err_reg      <= 1'b0;
            err_addr_reg <= 32'h0000_0000;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
            if (led_we) led_reg <= led_next;
            // an offending access wins over a clear; only the first offender is logged
            if (access_err) begin
                err_reg <= 1'b1;
                if (!err_reg) err_addr_reg <= Addr_in;
            end else if (errstat_clr) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign led_out = led_reg[15:0];
    assign err     = err_reg;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: lane formatting, MMIO window, error log, cycle counter, reset.
module tb_dm_responder;

    logic        clk;
    logic        reset;
    logic        mem_w;
    logic [31:0] Addr_in;
    logic [31:0] Data_in;
    logic [2:0]  dmType;
    logic [31:0] Data_out;
    logic [15:0] led_out;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    dm_responder #(.DEPTH_WORDS(128)) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_w    (mem_w),
        .Addr_in  (Addr_in),
        .Data_in  (Data_in),
        .dmType   (dmType),
        .Data_out (Data_out),
        .led_out  (led_out),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
            $display("[TB] %-16s observed %08h expected %08h ok", tag, obs, exp);
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // apply one access just after the falling edge; it commits on the following rising edge
    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] t);
        @(negedge clk);
        mem_w   = w;
        Addr_in = a;
        Data_in = d;
        dmType  = t;
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        mem_w   = 1'b0;
        Addr_in = 32'h0;
        Data_in = 32'h0;
        dmType  = 3'b000;

        #2;
        check("rst_led", {16'h0, led_out}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        Addr_in = 32'hFFFF_FF04;
        #1;
        check("rst_cycle_rd", Data_out, 32'h0);
        Addr_in = 32'h0;

        @(negedge clk);
        reset   = 1'b1;
        Addr_in = 32'hFFFF_FF04;
        #1;
        check("cycle_first", Data_out, 32'h0);
        drive(0, 32'hFFFF_FF04, 32'h0, 3'b000);
        check("cycle_second", Data_out, 32'h1);

        // lane extraction
        drive(1, 32'h0000_0000, 32'h0BAD_F00D, 3'b000);
        drive(1, 32'h0000_0010, 32'h8899_AABB, 3'b000);
        drive(0, 32'h0000_0011, 32'h0, 3'b011);
        check("ld_byte_s", Data_out, 32'hFFFF_FFAA);
        drive(0, 32'h0000_0011, 32'h0, 3'b100);
        check("ld_byte_u", Data_out, 32'h0000_00AA);
        drive(0, 32'h0000_0012, 32'h0, 3'b001);
        check("ld_half_s", Data_out, 32'hFFFF_8899);
        drive(0, 32'h0000_0012, 32'h0, 3'b010);
        check("ld_half_u", Data_out, 32'h0000_8899);
        drive(0, 32'h0000_0010, 32'h0, 3'b101);
        check("ld_code101", Data_out, 32'h8899_AABB);

        // byte store merge and same-cycle/next-cycle visibility
        drive(1, 32'h0000_0020, 32'h1122_3344, 3'b000);
        drive(1, 32'h0000_0023, 32'h0000_005A, 3'b011);
        check("st_same_cycle", Data_out, 32'h0000_0011);
        drive(0, 32'h0000_0020, 32'h0, 3'b000);
        check("st_next_cycle", Data_out, 32'h5A22_3344);

        // misaligned load and error log
        drive(0, 32'h0000_0006, 32'h0, 3'b000);
        check("misal_ld", Data_out, 32'h0);
        check("err_before", {31'h0, err}, 32'h0);
        drive(0, 32'h0000_0000, 32'h0, 3'b000);
        check("err_set", {31'h0, err}, 32'h1);
        drive(1, 32'h0000_0010, 32'hCAFE_F00D, 3'b000);
        drive(0, 32'hFFFF_FF0C, 32'h0, 3'b000);
        check("erraddr_kept", Data_out, 32'h0000_0006);
        drive(0, 32'hFFFF_FF08, 32'h0, 3'b000);
        check("errstat_rd", Data_out, 32'h1);
        drive(1, 32'hFFFF_FF08, 32'h0, 3'b000);
        drive(0, 32'h0000_0000, 32'h0, 3'b000);
        check("err_clr", {31'h0, err}, 32'h0);
        drive(0, 32'hFFFF_FF0C, 32'h0, 3'b000);
        check("erraddr_retain", Data_out, 32'h0000_0006);

        // misaligned store to ERRSTAT sets rather than clears
        drive(1, 32'hFFFF_FF0A, 32'h0, 3'b000);
        check("misal_st_pre", {31'h0, err}, 32'h0);
        drive(0, 32'hFFFF_FF0C, 32'h0, 3'b000);
        check("misal_st_err", {31'h0, err}, 32'h1);
        check("misal_st_addr", Data_out, 32'hFFFF_FF0A);
        drive(1, 32'hFFFF_FF08, 32'h0, 3'b000);
        drive(0, 32'hFFFF_FF08, 32'h0, 3'b000);
        check("errstat_clr_rd", Data_out, 32'h0);

        // CYCLE write and reserved window: no effect, no error
        drive(1, 32'hFFFF_FF04, 32'h0, 3'b000);
        drive(1, 32'hFFFF_FF40, 32'h0000_1234, 3'b000);
        drive(0, 32'hFFFF_FF40, 32'h0, 3'b000);
        check("reserved_rd", Data_out, 32'h0);
        check("ro_no_err", {31'h0, err}, 32'h0);

        // LED register lanes
        drive(1, 32'hFFFF_FF02, 32'h0000_BEEF, 3'b001);
        drive(0, 32'hFFFF_FF00, 32'h0, 3'b000);
        check("led_half_hi", {16'h0, led_out}, 32'h0);
        check("led_rd_hi", Data_out, 32'hBEEF_0000);
        drive(1, 32'hFFFF_FF00, 32'h0000_C0DE, 3'b000);
        drive(0, 32'hFFFF_FF00, 32'h0, 3'b000);
        check("led_word", {16'h0, led_out}, 32'h0000_C0DE);

        // out-of-range accesses
        drive(0, 32'h0002_0000, 32'h0, 3'b000);
        check("oor_ld", Data_out, 32'h0);
        drive(1, 32'h0002_0000, 32'hDEAD_BEEF, 3'b000);
        check("oor_err", {31'h0, err}, 32'h1);
        drive(0, 32'h0000_0000, 32'h0, 3'b000);
        check("oor_no_alias", Data_out, 32'h0BAD_F00D);

        // counter wrap
        @(negedge clk);
        force dut.cycle_reg = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_reg;
        mem_w   = 1'b0;
        Addr_in = 32'hFFFF_FF04;
        dmType  = 3'b000;
        #1;
        check("cycle_max", Data_out, 32'hFFFF_FFFF);
        drive(0, 32'hFFFF_FF04, 32'h0, 3'b000);
        check("cycle_wrap", Data_out, 32'h0);
        drive(0, 32'hFFFF_FF04, 32'h0, 3'b000);
        check("cycle_after_wrap", Data_out, 32'h1);

        // asynchronous reset in the middle of an LED store
        drive(1, 32'hFFFF_FF00, 32'h0000_1111, 3'b000);
        reset = 1'b0;
        #1;
        check("arst_led", {16'h0, led_out}, 32'h0);
        check("arst_err", {31'h0, err}, 32'h0);
        mem_w   = 1'b0;
        Addr_in = 32'hFFFF_FF04;
        #1;
        check("arst_cycle", Data_out, 32'h0);
        mem_w   = 1'b1;
        Addr_in = 32'hFFFF_FF00;
        @(negedge clk);
        reset   = 1'b1;
        mem_w   = 1'b0;
        #1;
        check("arst_store_lost", Data_out, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the single-cycle RISC-V core: the memory-side end of the core's `mem_w` / address / store-data / `dmType` / load-data interface. It formats stores into byte lanes, extracts and sign- or zero-extends loads, and hosts a small memory-mapped I/O window. The window holds an LED register, a free-running cycle counter and a sticky misalignment/range error log. It sits between the core and the board top level, and replaces a bare RAM.

## Interface
- `DEPTH_WORDS`, default 128: RAM size in 32-bit words; a power of two.
- `clk in 1`: single clock; all state updates on the rising edge.
- `reset in 1`: asynchronous, active-low reset.
- `mem_w in 1`: store strobe from the core; the access is a load when low.
- `Addr_in in 32`: byte address, taken from the core's ALU result.
- `Data_in in 32`: store data (rs2 value); the low bits are used for byte and half stores.
- `dmType in 3`: access width/sign, using the `dm_*` codes from the shared defines.
- `Data_out out 32`: load data returned to the core's write-back mux.
- `led_out out 16`: LED register, low 16 bits.
- `err out 1`: sticky access-error flag.

## Operation
- Address decode:
  - RAM when `Addr_in[31:16]==0` and word index `< DEPTH_WORDS`.
  - MMIO when `Addr_in[31:8]==24'hFFFFFF`.
  - Anything else is out-of-range.
- dmType codes (shared): `dm_word`=000, `dm_halfword`=001, `dm_halfword_unsigned`=010, `dm_byte`=011, `dm_byte_unsigned`=100. Codes 101–111 are treated as `dm_word`.
- Store lanes:
  - byte: `Data_in[7:0]` to lane `Addr_in[1:0]`.
  - half: `Data_in[15:0]` to lanes {1,0} or {3,2} selected by `Addr_in[1]`.
  - word: all four lanes.
  - Unselected lanes are unchanged.
- Load extract: same lane selection. `dm_byte` and `dm_halfword` sign-extend; the unsigned variants zero-extend.
- Misaligned access: half with `Addr_in[0]=1`, or word with `Addr_in[1:0]!=0`.
  - Store is suppressed.
  - Load returns 0.
- Error capture: a misaligned or out-of-range access sets `err`. `err_addr` latches `Addr_in` only on the 0→1 transition of `err` (first offender kept).
- MMIO registers (word offset; byte/half lane rules apply to reads and writes):
  - 0x00 LED: RW, 32-bit; `led_out` = bits [15:0].
  - 0x04 CYCLE: RO. Increments every clock and wraps 0xFFFFFFFF→0. Writes are ignored and do not set `err`.
  - 0x08 ERRSTAT: reads `{31'b0, err}`. Any aligned store clears `err`. `err_addr` is retained until the next capture.
  - 0x0C ERRADDR: RO.
  - 0x10–0xFF: read 0, writes dropped, no error.
- Out-of-range load returns 0; out-of-range store is dropped.
- A misaligned store to ERRSTAT does not clear `err`. It sets `err`, capturing only if `err` was already 0.

## Timing
- Loads are combinational, with zero latency: `Data_out` is valid in the same cycle as `Addr_in`/`dmType`, as the single-cycle core requires.
- Stores commit at the rising edge where `mem_w=1`.
- A load in the same cycle as a store to the same address returns the pre-store value.
- A store followed by a load in the next cycle returns the new value.
- Error flag: `err` rises at the edge that ends the offending cycle. ERRSTAT read in that same cycle still shows the old value.
- CYCLE: a read returns the registered count for that cycle; consecutive-cycle reads differ by exactly 1.
- Reset (asserted low, asynchronous): `led_out`=0, CYCLE=0, `err`=0, `err_addr`=0. RAM contents are not reset. `Data_out` follows its combinational inputs (0 for MMIO LED/CYCLE/err reads during reset).
- Reset mid-store: the store is lost. CYCLE restarts from 0 on the first edge after release and reads 1 one cycle later.

## Structure
- `dm_*` codes and the MMIO base/offset constants go in the shared `ctrl_encode_def.v` include; no local literals.
- Sub-module `dm_lane`: combinational. Computes store byte-enables, write data and load extraction from `Addr_in[1:0]`, `dmType`, store data and raw read word. Also flags misalignment. Reused for both RAM and MMIO paths.
- Top level `dm_responder`: address decode, RAM array, MMIO registers, counter, error log, read mux.

## Test plan
- Store word 0x8899AABB @0x10; load byte @0x11 → 0xFFFFFFAA; `dm_byte_unsigned` @0x11 → 0x000000AA; `dm_halfword` @0x12 → 0xFFFF8899.
- Store byte 0x5A @0x23 onto word 0x11223344 → word 0x5A223344. Same-cycle load @0x20 → 0x11223344; next-cycle load → 0x5A223344.
- Load word @0x06 → 0 and `err`=1 next cycle. Store word @0x10 cycles later leaves ERRADDR=0x06. Store to 0xFFFFFF08 → `err`=0 next cycle.
- Store half 0xBEEF to 0xFFFFFF02 → `led_out` unchanged in [15:0]. Store word 0x0000C0DE to 0xFFFFFF00 → `led_out`=0xC0DE.
- Release reset, read CYCLE on two consecutive cycles → difference 1. Force count to 0xFFFFFFFF → next read 0. Assert reset mid-run → `led_out`, `err`, CYCLE = 0 immediately, without a clock edge.
- Load from 0x00020000 → 0 and `err`=1. Store there → RAM unchanged (readback of aliased index 0 unaffected).
